asrv32_stage_controller: RTL and testbench

ASRV32_STAGE_CONTROLLER -- requirements
Module: asrv32_stage_controller

---
 rtl/asrv32_stage_controller.sv | 151 +++++++++++++++
 tb/tb_asrv32_stage_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_stage_controller.sv
// ============================================================================
// Module   : asrv32_stage_controller
// Brief    : Five-stage sequencer for the ASRV32 core. Walks each instruction
//            through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, bounds every bus
//            wait with a timeout, honours stalls only in non-bus stages and
//            counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module asrv32_stage_controller #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_inst_ack,
    input  logic        i_data_ack,
    input  logic        i_mem_access,
    input  logic        i_go_to_trap,
    output logic [4:0]  o_stage,
    output logic        o_inst_req,
    output logic        o_data_req,
    output logic        o_writeback_en,
    output logic        o_bus_timeout,
    output logic [31:0] o_instret
);

    // One-hot encoding so the state register can drive o_stage directly.
    typedef enum logic [4:0] {
        ST_FETCH     = 5'b00001,
        ST_DECODE    = 5'b00010,
        ST_EXECUTE   = 5'b00100,
        ST_MEMORY    = 5'b01000,
        ST_WRITEBACK = 5'b10000
    } stage_e;

    stage_e      state_q;
    logic [7:0]  wait_cnt_q;
    logic        timeout_q;
    logic        trap_q;
    logic [31:0] instret_q;

    logic        w_wait_expired;
    logic        w_wb_active;
    logic        w_retire;

    // The wait counter starts at zero on entry, so the state lasts TIMEOUT+1
    // cycles before the forced exit.
    assign w_wait_expired = (wait_cnt_q == TIMEOUT);

    // Writeback commits only when not frozen by the downstream stall.
    assign w_wb_active    = (state_q == ST_WRITEBACK) && !i_stall;

    // Timed-out or trapped instructions reach WRITEBACK but never retire.
    assign w_retire       = w_wb_active && !timeout_q && !trap_q;

    assign o_stage        = state_q;
    assign o_inst_req     = (state_q == ST_FETCH);
    assign o_data_req     = (state_q == ST_MEMORY);
    assign o_writeback_en = w_wb_active;
    assign o_bus_timeout  = timeout_q;
    assign o_instret      = instret_q;

    // Stage sequencing, bus-wait timeout, trap latch and retire counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            trap_q     <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            if (w_retire) begin
                instret_q <= instret_q + 32'd1;
            end

            case (state_q)
                ST_FETCH: begin
                    // Stall is ignored: an outstanding fetch is never frozen.
                    if (i_inst_ack) begin
                        state_q    <= ST_DECODE;
                        wait_cnt_q <= 8'd0;
                    end else if (w_wait_expired) begin
                        state_q    <= ST_WRITEBACK;
                        timeout_q  <= 1'b1;
                        wait_cnt_q <= 8'd0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                ST_DECODE: begin
                    if (!i_stall) begin
                        state_q <= ST_EXECUTE;
                    end
                end

                ST_EXECUTE: begin
                    // A pending trap bypasses the memory access entirely.
                    if (!i_stall) begin
                        if (i_go_to_trap) begin
                            state_q <= ST_WRITEBACK;
                            trap_q  <= 1'b1;
                        end else if (i_mem_access) begin
                            state_q    <= ST_MEMORY;
                            wait_cnt_q <= 8'd0;
                        end else begin
                            state_q <= ST_WRITEBACK;
                        end
                    end
                end

                ST_MEMORY: begin
                    // Acknowledge or trap abort wins over the timeout check.
                    if (i_data_ack || i_go_to_trap) begin
                        state_q    <= ST_WRITEBACK;
                        trap_q     <= i_go_to_trap;
                        wait_cnt_q <= 8'd0;
                    end else if (w_wait_expired) begin
                        state_q    <= ST_WRITEBACK;
                        timeout_q  <= 1'b1;
                        wait_cnt_q <= 8'd0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                ST_WRITEBACK: begin
                    // Per-instruction flags are dropped as the next fetch begins.
                    if (!i_stall) begin
                        state_q    <= ST_FETCH;
                        wait_cnt_q <= 8'd0;
                        timeout_q  <= 1'b0;
                        trap_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= ST_FETCH;
                    wait_cnt_q <= 8'd0;
                    timeout_q  <= 1'b0;
                    trap_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_asrv32_stage_controller.sv
// ============================================================================
// Module   : tb_asrv32_stage_controller
// Brief    : Self-checking bench for asrv32_stage_controller (TIMEOUT = 4).
//            Each row of stimulus carries the outputs expected in that cycle;
//            the expectation is queued when the row is driven and compared
//            once the DUT outputs have settled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asrv32_stage_controller;

    localparam logic [4:0] SF = 5'h01;
    localparam logic [4:0] SD = 5'h02;
    localparam logic [4:0] SE = 5'h04;
    localparam logic [4:0] SM = 5'h08;
    localparam logic [4:0] SW = 5'h10;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_inst_ack;
    logic        i_data_ack;
    logic        i_mem_access;
    logic        i_go_to_trap;
    logic [4:0]  o_stage;
    logic        o_inst_req;
    logic        o_data_req;
    logic        o_writeback_en;
    logic        o_bus_timeout;
    logic [31:0] o_instret;

    typedef struct packed {
        logic       st;
        logic       ia;
        logic       da;
        logic       ma;
        logic       tr;
        logic [4:0] stg;
        logic       wb;
        logic       to;
        logic       rt;
    } row_t;

    row_t        stim[$];
    logic [40:0] sb[$];
    logic [31:0] exp_instret;
    int          checks;
    int          failures;

    logic [40:0] w_obs;
    assign w_obs = {o_stage, o_inst_req, o_data_req, o_writeback_en, o_bus_timeout, o_instret};

    asrv32_stage_controller #(
        .TIMEOUT(8'd4)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_stall        (i_stall),
        .i_inst_ack     (i_inst_ack),
        .i_data_ack     (i_data_ack),
        .i_mem_access   (i_mem_access),
        .i_go_to_trap   (i_go_to_trap),
        .o_stage        (o_stage),
        .o_inst_req     (o_inst_req),
        .o_data_req     (o_data_req),
        .o_writeback_en (o_writeback_en),
        .o_bus_timeout  (o_bus_timeout),
        .o_instret      (o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic string fmt(input logic [40:0] v);
        return $sformatf("stage=%h ireq=%b dreq=%b wb=%b to=%b instret=%0d",
                         v[40:36], v[35], v[34], v[33], v[32], v[31:0]);
    endfunction

    // Queue one cycle: inputs plus the outputs expected during that cycle.
    task automatic plan(input logic st, input logic ia, input logic da, input logic ma,
                        input logic tr, input logic [4:0] stg, input logic wb,
                        input logic to, input logic rt);
        row_t r;
        r = {st, ia, da, ma, tr, stg, wb, to, rt};
        stim.push_back(r);
    endtask

    // Drive the next row and push its expectation onto the scoreboard.
    task automatic apply_next();
        row_t        r;
        logic [40:0] e;
        r            = stim.pop_front();
        i_stall      = r.st;
        i_inst_ack   = r.ia;
        i_data_ack   = r.da;
        i_mem_access = r.ma;
        i_go_to_trap = r.tr;
        e = {r.stg, (r.stg == SF), (r.stg == SM), r.wb, r.to, exp_instret};
        sb.push_back(e);
        if (r.rt) exp_instret = exp_instret + 32'd1;
    endtask

    task automatic test_reset();
        logic [40:0] e;
        i_rst_n = 1'b0;
        i_stall = 1'b0; i_inst_ack = 1'b1; i_data_ack = 1'b0;
        i_mem_access = 1'b0; i_go_to_trap = 1'b0;
        exp_instret = 32'd0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            sb.push_back({SF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL reset[%0d] got %s expected %s", k, fmt(w_obs), fmt(e));
            end
        end
        @(negedge i_clk);
        i_inst_ack = 1'b0;
        i_rst_n    = 1'b1;
    endtask

    task automatic test_alu();
        logic [40:0] e;
        int          idx;
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,0,0, SE,0,0,0);
        plan(0,0,0,0,0, SW,1,0,1);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL alu row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
    endtask

    task automatic test_load();
        logic [40:0] e;
        int          idx;
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,1,0,0, SD,0,0,0);   // data ack outside MEMORY is ignored
        plan(0,1,0,1,0, SE,0,0,0);   // inst ack outside FETCH is ignored
        for (int k = 0; k < 3; k++) plan(1,0,0,0,0, SM,0,0,0);  // stall ignored
        plan(0,0,1,0,0, SM,0,0,0);
        plan(0,0,0,0,0, SW,1,0,1);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL load row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
    endtask

    task automatic test_timeout();
        logic [40:0] e;
        int          idx;
        // Fetch timeout, with a stalled WRITEBACK holding the flag.
        for (int k = 0; k < 5; k++) plan(0,0,0,0,0, SF,0,0,0);
        plan(1,0,0,0,0, SW,0,1,0);
        plan(0,0,0,0,0, SW,1,1,0);
        // Acknowledge on the fifth fetch cycle wins.
        for (int k = 0; k < 4; k++) plan(0,0,0,0,0, SF,0,0,0);
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,0,0, SE,0,0,0);
        plan(0,0,0,0,0, SW,1,0,1);
        // Memory timeout.
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,1,0, SE,0,0,0);
        for (int k = 0; k < 5; k++) plan(0,0,0,0,0, SM,0,0,0);
        plan(0,0,0,0,0, SW,1,1,0);
        // Data acknowledge on the fifth memory cycle wins.
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,1,0, SE,0,0,0);
        for (int k = 0; k < 4; k++) plan(0,0,0,0,0, SM,0,0,0);
        plan(0,0,1,0,0, SM,0,0,0);
        plan(0,0,0,0,0, SW,1,0,1);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL timeout row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
    endtask

    task automatic test_trap();
        logic [40:0] e;
        int          idx;
        // Trap in EXECUTE beats mem_access: MEMORY skipped.
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,1,1, SE,0,0,0);
        plan(0,0,0,0,0, SW,1,0,0);
        // Trap while in MEMORY aborts the access.
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,1,0, SE,0,0,0);
        plan(0,0,0,0,0, SM,0,0,0);
        plan(0,0,0,0,1, SM,0,0,0);
        plan(0,0,0,0,0, SW,1,0,0);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL trap row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
    endtask

    task automatic test_stall();
        logic [40:0] e;
        int          idx;
        plan(1,1,0,0,0, SF,0,0,0);   // stall ignored in FETCH
        plan(1,0,0,0,0, SD,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        for (int k = 0; k < 3; k++) plan(1,0,0,0,0, SE,0,0,0);
        plan(0,0,0,0,0, SE,0,0,0);
        for (int k = 0; k < 3; k++) plan(1,0,0,0,0, SW,0,0,0);
        plan(0,0,0,0,0, SW,1,0,1);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL stall row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [40:0] e;
        int          idx;
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,1,0, SE,0,0,0);
        plan(0,0,0,0,0, SM,0,0,0);
        plan(0,0,0,0,0, SM,0,0,0);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL rstmem row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
        // Still in MEMORY with the request up and five instructions retired.
        i_stall = 1'b0; i_inst_ack = 1'b0; i_data_ack = 1'b0;
        i_mem_access = 1'b0; i_go_to_trap = 1'b0;
        sb.push_back({SM, 1'b0, 1'b1, 1'b0, 1'b0, exp_instret});
        #1;
        e = sb.pop_front();
        checks++;
        if (w_obs !== e || o_instret !== 32'd5) begin
            failures++;
            $display("FAIL rstmem_inflight got %s expected %s (instret 5)", fmt(w_obs), fmt(e));
        end
        // Asynchronous reset between clock edges.
        i_rst_n = 1'b0;
        exp_instret = 32'd0;
        sb.push_back({SF, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        #1;
        e = sb.pop_front();
        checks++;
        if (w_obs !== e) begin
            failures++;
            $display("FAIL rstmem_async got %s expected %s", fmt(w_obs), fmt(e));
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        // Normal operation resumes after reset.
        plan(0,1,0,0,0, SF,0,0,0);
        plan(0,0,0,0,0, SD,0,0,0);
        plan(0,0,0,0,0, SE,0,0,0);
        plan(0,0,0,0,0, SW,1,0,1);
        plan(0,0,0,0,0, SF,0,0,0);
        idx = 0;
        while (stim.size() > 0) begin
            apply_next();
            #1;
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL rstmem_resume row%0d got %s expected %s", idx, fmt(w_obs), fmt(e));
            end
            idx++;
            @(negedge i_clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu();
        test_load();
        test_timeout();
        test_trap();
        test_stall();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
